pattern_ctrl: RTL and testbench

Frame-synchronous sequencer for the HDMI test-pattern generator. It picks the generator's pattern mode and single-colour level from a user pushbutton and an auto-cycle timer. Mode changes take effect only at a frame boundary, which is the leading edge of active VSYNC, so no frame ever shows a torn pattern. It sits between the board I/O (key, auto switch) and the pattern generator's `I_mode` / `I_single_*` inputs. It observes the generator's VS output.

---
 rtl/pattern_pkg.sv | 25 ++
 rtl/key_debounce.sv | 46 ++++
 rtl/pattern_ctrl.sv | 99 +++++++++
 tb/tb_pattern_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// pattern_pkg: shared mode codes, sequencer state encoding and mode-advance helper
//   MODE_*      : pattern-generator mode indices driven onto I_mode
//   seq_state_t : RUN = free running, PEND = manual advance waiting for a frame boundary
//   next_mode() : increment with wrap to MODE_COLORBAR after the highest used mode
package pattern_pkg;

    localparam logic [2:0] MODE_COLORBAR = 3'd0;
    localparam logic [2:0] MODE_GRID     = 3'd1;
    localparam logic [2:0] MODE_GRAY     = 3'd2;
    localparam logic [2:0] MODE_BLUE     = 3'd3;
    localparam logic [2:0] MODE_GREEN    = 3'd4;
    localparam logic [2:0] MODE_RED      = 3'd5;
    localparam logic [2:0] MODE_WHITE    = 3'd6;
    localparam logic [2:0] MODE_BLACK    = 3'd7;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } seq_state_t;

    function automatic logic [2:0] next_mode(input logic [2:0] mode, input logic [2:0] last);
        return (mode == last) ? MODE_COLORBAR : mode + 3'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces an active-low pushbutton, pulses on each accepted press
//   clk   in  : sampling clock
//   rst_n in  : asynchronous active-low reset
//   key_n in  : raw pushbutton, active-low, asynchronous to clk
//   press out : one-cycle pulse when the debounced level goes 1 -> 0 (releases are silent)
module key_debounce #(
    parameter int DEBOUNCE_CYC = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // press takes the old stable level, so it is 1 only for a 1 -> 0 acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable)
                cnt <= '0;
            else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= stable;
            end else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_ctrl.sv
// pattern_ctrl: frame-synchronous mode/gray-level sequencer for the HDMI test-pattern generator
//   I_pxl_clk  in  : pixel clock
//   I_rst_n    in  : asynchronous active-low reset
//   I_vs       in  : generator VS, synchronous to I_pxl_clk
//   I_vs_pol   in  : active VS level (1 = active-high)
//   I_key_n    in  : advance pushbutton, active-low, asynchronous
//   I_auto     in  : auto-cycle enable (static)
//   O_mode     out : pattern mode to the generator
//   O_single_* out : gray-ramp level, identical on r/g/b
//   O_switch   out : one-cycle pulse on every mode change
module pattern_ctrl
    import pattern_pkg::*;
#(
    parameter int DEBOUNCE_CYC    = 270000,
    parameter int FRAMES_PER_MODE = 120,
    parameter int MODE_LAST       = 6,
    parameter int GRAY_STEP       = 1
) (
    input  logic       I_pxl_clk,
    input  logic       I_rst_n,
    input  logic       I_vs,
    input  logic       I_vs_pol,
    input  logic       I_key_n,
    input  logic       I_auto,
    output logic [2:0] O_mode,
    output logic [7:0] O_single_r,
    output logic [7:0] O_single_g,
    output logic [7:0] O_single_b,
    output logic       O_switch
);

    localparam int FW = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_MODE - 1);

    logic          vs_act;
    logic          vs_act_d;
    logic          tick;
    logic          press;
    logic          due;
    logic          advance;
    logic [FW-1:0] frame_cnt;
    logic [7:0]    gray;
    seq_state_t    state;
    seq_state_t    state_nxt;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key (
        .clk  (I_pxl_clk),
        .rst_n(I_rst_n),
        .key_n(I_key_n),
        .press(press)
    );

    // tick is combinational so outputs update on the very edge that first samples active VS;
    // vs_act_d resets to 1 so a VS already active at reset release does not count as an edge
    assign vs_act = I_vs ^ ~I_vs_pol;
    assign tick   = vs_act & ~vs_act_d;

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // a press in RUN always moves to PEND, even on a tick cycle: the tick itself is
    // judged against the old state, so the request lands on the following tick
    always_comb begin
        state_nxt = (state == ST_RUN) ? (press ? ST_PEND : ST_RUN)
                                      : (tick  ? ST_RUN  : ST_PEND);
    end

    always_comb begin
        due     = I_auto & (frame_cnt == FRAME_LAST);
        advance = tick & ((state == ST_PEND) | due);
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vs_act_d  <= 1'b1;
            frame_cnt <= '0;
            O_mode    <= MODE_COLORBAR;
            gray      <= '0;
            O_switch  <= 1'b0;
        end else begin
            vs_act_d  <= vs_act;
            frame_cnt <= (!I_auto || advance) ? '0 : tick ? frame_cnt + 1'b1 : frame_cnt;
            O_mode    <= advance ? next_mode(O_mode, 3'(MODE_LAST)) : O_mode;
            gray      <= tick ? gray + 8'(GRAY_STEP) : gray;
            O_switch  <= advance;
        end
    end

    assign O_single_r = gray;
    assign O_single_g = gray;
    assign O_single_b = gray;

endmodule

// File: tb/tb_pattern_ctrl.sv
// tb_pattern_ctrl: scoreboard bench for pattern_ctrl with a tick-level reference model
module tb_pattern_ctrl;

    localparam int DEB  = 4;
    localparam int FPM  = 3;
    localparam int LAST = 6;
    localparam int STEP = 16;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] gray;
        logic       sw;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs;
    logic       vs_pol;
    logic       key_n;
    logic       auto;
    logic [2:0] O_mode;
    logic [7:0] O_single_r;
    logic [7:0] O_single_g;
    logic [7:0] O_single_b;
    logic       O_switch;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 0;
    logic [2:0] pm;
    logic [7:0] pg;

    int m_ticks;
    int m_advs;
    int m_fc;
    bit m_pend;

    pattern_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .FRAMES_PER_MODE(FPM),
        .MODE_LAST(LAST),
        .GRAY_STEP(STEP)
    ) dut (
        .I_pxl_clk (clk),
        .I_rst_n   (rst_n),
        .I_vs      (vs),
        .I_vs_pol  (vs_pol),
        .I_key_n   (key_n),
        .I_auto    (auto),
        .O_mode    (O_mode),
        .O_single_r(O_single_r),
        .O_single_g(O_single_g),
        .O_single_b(O_single_b),
        .O_switch  (O_switch)
    );

    always #5 clk = ~clk;

    // Reference: mode is the number of advances modulo the mode count, gray is ticks*STEP mod 256
    task automatic model_tick();
        exp_t x;
        bit   adv;
        m_ticks++;
        adv = m_pend || (auto && m_fc == FPM - 1);
        if (adv) begin
            m_advs++;
            m_fc   = 0;
            m_pend = 0;
        end else
            m_fc = auto ? m_fc + 1 : 0;
        x.mode = 3'(m_advs % (LAST + 1));
        x.gray = 8'((m_ticks * STEP) % 256);
        x.sw   = adv;
        sb.push_back(x);
    endtask

    task automatic model_reset();
        m_ticks = 0;
        m_advs  = 0;
        m_fc    = 0;
        m_pend  = 0;
    endtask

    task automatic vs_pulse(input int act, input int gap);
        @(negedge clk);
        vs = vs_pol;
        model_tick();
        repeat (act) @(negedge clk);
        vs = ~vs_pol;
        repeat (gap) @(negedge clk);
    endtask

    task automatic press_key(input int hold);
        @(negedge clk);
        key_n = 1'b0;
        repeat (hold) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
        m_pend = 1;
    endtask

    task automatic glitch(input int low);
        @(negedge clk);
        key_n = 1'b0;
        repeat (low) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic set_auto(input bit a);
        @(negedge clk);
        auto = a;
        if (!a) m_fc = 0;
        @(negedge clk);
    endtask

    task automatic set_pol(input bit p);
        @(negedge clk);
        vs_pol = p;
        vs     = ~p;
        repeat (2) @(negedge clk);
    endtask

    // Key low so that the debounced press pulse coincides with a VS leading edge
    task automatic press_on_tick();
        @(negedge clk);
        key_n = 1'b0;
        repeat (DEB + 2) @(posedge clk);
        @(negedge clk);
        vs = vs_pol;
        model_tick();
        m_pend = 1;
        @(negedge clk);
        vs = ~vs_pol;
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (O_mode != 0 || O_single_r != 0 || O_single_g != 0 || O_single_b != 0 || O_switch != 0) begin
                failures++;
                $display("FAIL reset_values: mode=%0d r=%0h g=%0h b=%0h switch=%0b, required all 0",
                         O_mode, O_single_r, O_single_g, O_single_b, O_switch);
            end
            pm = O_mode;
            pg = O_single_r;
        end else if (done) begin
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL scoreboard_drain: %0d expected updates never seen, required 0", sb.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else if (O_mode != pm || O_single_r != pg || O_switch) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_update: mode=%0d gray=%0h switch=%0b, required no change from mode=%0d gray=%0h",
                         O_mode, O_single_r, O_switch, pm, pg);
            end else begin
                e = sb.pop_front();
                if (O_mode != e.mode || O_single_r != e.gray || O_single_g != e.gray ||
                    O_single_b != e.gray || O_switch != e.sw) begin
                    failures++;
                    $display("FAIL tick_update: mode=%0d r=%0h g=%0h b=%0h switch=%0b, required mode=%0d gray=%0h switch=%0b",
                             O_mode, O_single_r, O_single_g, O_single_b, O_switch, e.mode, e.gray, e.sw);
                end
            end
            pm = O_mode;
            pg = O_single_r;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        rst_n  = 1'b0;
        vs     = 1'b1;
        vs_pol = 1'b0;
        key_n  = 1'b1;
        auto   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        auto = 1'b1;
        for (int i = 0; i < 24; i++) vs_pulse(2, 5);

        set_auto(1'b0);
        vs_pulse(2, 20);
        press_key(10);
        vs_pulse(2, 5);
        vs_pulse(2, 5);

        @(negedge clk);
        key_n = 1'b0;
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        repeat (2) @(negedge clk);
        key_n = 1'b0;
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) vs_pulse(1, 4);

        set_auto(1'b1);
        for (int i = 0; i < 4 && m_fc != FPM - 1; i++) vs_pulse(1, 4);
        press_on_tick();
        for (int i = 0; i < 4; i++) vs_pulse(1, 4);

        set_pol(1'b1);
        for (int i = 0; i < 6; i++) vs_pulse(i % 5 + 1, 6);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      vs_pulse($urandom_range(1, 5), $urandom_range(1, 8));
            else if (r < 80) press_key($urandom_range(6, 15));
            else if (r < 90) glitch($urandom_range(1, 3));
            else if (r < 95) set_auto(~auto);
            else             set_pol(~vs_pol);
        end

        set_auto(1'b0);
        for (int i = 0; i < 8 && (m_advs % (LAST + 1)) != 4; i++) begin
            press_key(8);
            vs_pulse(2, 4);
        end
        press_key(8);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        vs_pulse(2, 6);
        vs_pulse(2, 6);

        repeat (40) @(negedge clk);
        vs_pulse(40, 40);
        done = 1;
    end

endmodule
